temp_sr_capture: RTL and testbench
==================================

Name: temp_sr_capture

Overview:
Downstream readout stage for the temperature-sensor digital block. It waits a fixed conversion time, then drives that block's shift clock and deserializes its serial counter output (sr_out) into a parallel word, MSB first. Completed words are pushed into a small FIFO. A first-word-fall-through read port and a level interrupt serve the management SoC through the logic analyzer / GPIO wrapper glue.

Parameters:
DATA_W, 16, counter word width (bits shifted per conversion)
SHIFT_DIV, 4, shift_clk half-period in clock cycles (must be >= 3)
SETTLE_CYC, 8, clock cycles waited after start before shifting begins (>= 1)
FIFO_DEPTH, 4, result FIFO entries (power of two, >= 2)

Ports:
wb_clk_i  input  1  single clock for all logic
wb_rst_i  input  1  reset; asynchronous, active-high
start  input  1  one-cycle conversion request; ignored while busy=1
sr_in  input  1  serial data from the sensor shift register; asynchronous, 2-flop synchronized internally
shift_clk_o  output  1  generated shift clock to the sensor shift register
busy  output  1  high from the cycle after an accepted start until the push completes
rd_en  input  1  pop the FIFO head; ignored when empty
rd_data  output  DATA_W  FIFO head (first-word-fall-through); 0 when empty
fifo_empty  output  1  FIFO holds no words
fifo_full  output  1  FIFO holds FIFO_DEPTH words
overflow  output  1  sticky: a word was dropped because the FIFO was full
clr_ovf  input  1  one-cycle clear of overflow
irq  output  1  equals !fifo_empty

Behaviour:
- Reset (async assert, sync release): FSM=IDLE, shift_clk_o=0, busy=0, FIFO pointers and count=0, fifo_empty=1, fifo_full=0, rd_data=0, overflow=0, irq=0, sync flops=0.
- FSM states: IDLE, SETTLE, SHIFT, PUSH.
- IDLE: shift_clk_o=0. start=1 moves to SETTLE next cycle; busy rises in the same cycle.
- SETTLE: counts SETTLE_CYC cycles, then moves to SHIFT with bit counter=DATA_W-1 and phase counter=0.
- SHIFT: each bit period is SHIFT_DIV cycles low, then SHIFT_DIV cycles high.
  - On the last low-phase cycle, synchronized sr_in is shifted into the LSB of the assembly register (shreg <= {shreg[DATA_W-2:0], sr_sync}). The first sample is therefore the MSB already present before any edge.
  - After the high phase of the last bit, go to PUSH. Exactly DATA_W rising edges are emitted per conversion.
- PUSH: one cycle. Writes shreg into the FIFO if it is not full, otherwise drops the word and sets overflow. Then returns to IDLE with busy=0.
- busy duration: exactly SETTLE_CYC + 2*SHIFT_DIV*DATA_W + 1 cycles.
- A start during busy is dropped and not queued. A start in the same cycle busy falls (PUSH) is also dropped.
- FIFO:
  - rd_en with !fifo_empty advances the read pointer; rd_data shows the new head next cycle.
  - A push and a pop in the same cycle when full: both happen, no overflow, count unchanged.
  - A push and a pop when empty: push only, and the word appears on rd_data the next cycle.
  - Pointers wrap modulo FIFO_DEPTH; count is $clog2(FIFO_DEPTH)+1 bits.
- overflow: set by a dropped push, cleared by clr_ovf. If both occur in the same cycle, set wins.
- Reset mid-conversion: aborts immediately, shift_clk_o goes low asynchronously, and the partial word is discarded.
- All outputs are registered. There is no combinational path from any input to any output.

Decomposition:
- Package temp_sr_pkg: FSM state enum (IDLE/SETTLE/SHIFT/PUSH); localparams for counter widths ($clog2(SETTLE_CYC+1), $clog2(SHIFT_DIV), $clog2(DATA_W)); default parameter constants.
- Sub-module sync_fifo (WIDTH, DEPTH): FWFT storage, pointers, count, full/empty. The top level holds the FSM, clock divider, synchronizer and overflow logic.

Test Plan:
- Reset defaults: assert wb_rst_i mid-SHIFT, with shift_clk_o high -> shift_clk_o=0 asynchronously; fifo_empty=1, busy=0, overflow=0, irq=0 held through release.
- Single conversion (defaults): sensor model presents 0xA5C3 MSB first, updating on each shift_clk_o rise; start pulse at cycle 0 ->
  - busy high for 8+128+1=137 cycles;
  - exactly 16 rising edges, each 8 cycles apart;
  - fifo_empty=0 and irq=1 after the push;
  - rd_data=0xA5C3; after rd_en, fifo_empty=1 and rd_data=0.
- Start while busy: second start 20 cycles into a conversion -> ignored; exactly 16 edges, one FIFO entry.
- Fill and overflow: 5 conversions with words 0x0001..0x0005, no reads ->
  - fifo_full=1 after the 4th;
  - 5th dropped and overflow=1;
  - reads return 0x0001..0x0004;
  - clr_ovf then gives overflow=0.
- Simultaneous push/pop when full: FIFO full; rd_en asserted exactly in the PUSH cycle of word 0x1234 -> no overflow, fifo_full stays 1, 0x1234 read last.
- Extreme data: words 0x0000 and 0xFFFF back-to-back -> both read intact, in order.

Source files
------------

// File: rtl/temp_sr_capture_pkg.sv
// Shared definitions for the temperature-sensor readout stage.
//   - Default parameter values for the top level.
//   - Readout FSM state type.
//   - cnt_w(): width of a counter that must hold values 0..n-1 (never below 1 bit).
package temp_sr_pkg;

  localparam int DATA_W_DEF     = 16;
  localparam int SHIFT_DIV_DEF  = 4;
  localparam int SETTLE_CYC_DEF = 8;
  localparam int FIFO_DEPTH_DEF = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SHIFT  = 2'd2,
    PUSH   = 2'd3
  } state_t;

  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/temp_sr_capture_if.sv
// Bundle of the readout stage's sensor-side and SoC-side signals.
//   master : conversion requester / FIFO reader / sensor (drives start, sr_in, rd_en, clr_ovf)
//   slave  : temp_sr_capture itself
interface temp_sr_capture_if #(
  parameter int DATA_W = 16
);
  logic              start;
  logic              sr_in;
  logic              shift_clk_o;
  logic              busy;
  logic              rd_en;
  logic [DATA_W-1:0] rd_data;
  logic              fifo_empty;
  logic              fifo_full;
  logic              overflow;
  logic              clr_ovf;
  logic              irq;

  modport master (
    output start, sr_in, rd_en, clr_ovf,
    input  shift_clk_o, busy, rd_data, fifo_empty, fifo_full, overflow, irq
  );

  modport slave (
    input  start, sr_in, rd_en, clr_ovf,
    output shift_clk_o, busy, rd_data, fifo_empty, fifo_full, overflow, irq
  );
endinterface

// File: rtl/temp_sr_capture_sync_fifo.sv
// First-word-fall-through FIFO for completed conversion words.
// Ports: clk/rst (async, active-high), wr_en/wr_data (push, dropped when full
// unless a pop happens in the same cycle), rd_en (pop, ignored when empty),
// rd_data (registered head, 0 when empty), empty/full/nonempty (registered flags).
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic             full,
  output logic             nonempty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr, rd_ptr_n;
  logic [CW-1:0]    count, count_n;
  logic [WIDTH-1:0] rd_data_n;
  logic             do_rd, do_wr;

  assign do_rd    = rd_en & ~empty;
  assign do_wr    = wr_en & (~full | do_rd);
  assign rd_ptr_n = rd_ptr + PW'(do_rd);
  assign count_n  = count + CW'(do_wr) - CW'(do_rd);

  // Registered head: if the new head slot is the one being written this
  // cycle, forward the incoming word instead of the stale memory content.
  always_comb begin
    rd_data_n = '0;
    if (count_n != '0) begin
      if (do_wr && (rd_ptr_n == wr_ptr)) rd_data_n = wr_data;
      else                               rd_data_n = mem[rd_ptr_n];
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      rd_data  <= '0;
      empty    <= 1'b1;
      full     <= 1'b0;
      nonempty <= 1'b0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + PW'(1);
      rd_ptr   <= rd_ptr_n;
      count    <= count_n;
      rd_data  <= rd_data_n;
      empty    <= (count_n == '0);
      full     <= (count_n == CW'(DEPTH));
      nonempty <= (count_n != '0);
    end
  end
endmodule

// File: rtl/temp_sr_capture.sv
// Temperature-sensor readout: waits SETTLE_CYC cycles after start, generates
// DATA_W shift clock pulses, deserializes sr_in MSB first and pushes the word
// into a FWFT FIFO.
// Ports: wb_clk_i, wb_rst_i (async, active-high), bus (slave modport) carrying
// start/busy, sr_in/shift_clk_o, FIFO read port, overflow/clr_ovf and irq.
//
// state  | meaning
// IDLE   | waiting for start, shift clock parked low
// SETTLE | conversion time, SETTLE_CYC cycles
// SHIFT  | DATA_W shift clock periods, sample on last low-phase cycle
// PUSH   | one cycle: write word to FIFO or flag overflow
module temp_sr_capture
  import temp_sr_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int SHIFT_DIV  = SHIFT_DIV_DEF,
  parameter int SETTLE_CYC = SETTLE_CYC_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  temp_sr_capture_if.slave   bus
);
  localparam int SET_W = cnt_w(SETTLE_CYC + 1);
  localparam int PH_W  = cnt_w(SHIFT_DIV);
  localparam int BIT_W = cnt_w(DATA_W);

  state_t            state_q, state_d;
  logic [SET_W-1:0]  settle_q, settle_d;
  logic [PH_W-1:0]   ph_q, ph_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic              sclk_q, sclk_d;
  logic              busy_q;
  logic [1:0]        sync_q;
  logic              ovf_q;
  logic              push, drop;
  logic [DATA_W-1:0] fifo_rd_data;
  logic              fifo_empty, fifo_full, fifo_nonempty;

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    ph_d     = ph_q;
    bit_d    = bit_q;
    shreg_d  = shreg_q;
    sclk_d   = sclk_q;
    push     = 1'b0;
    case (state_q)
      IDLE: begin
        sclk_d = 1'b0;
        if (bus.start) begin
          state_d  = SETTLE;
          settle_d = SET_W'(SETTLE_CYC - 1);
        end
      end
      SETTLE: begin
        if (settle_q == '0) begin
          state_d = SHIFT;
          bit_d   = BIT_W'(DATA_W - 1);
          ph_d    = '0;
          sclk_d  = 1'b0;
        end else begin
          settle_d = settle_q - SET_W'(1);
        end
      end
      SHIFT: begin
        if (ph_q == PH_W'(SHIFT_DIV - 1)) begin
          ph_d = '0;
          if (!sclk_q) begin
            // End of low phase: sample, then raise the shift clock.
            shreg_d = {shreg_q[DATA_W-2:0], sync_q[1]};
            sclk_d  = 1'b1;
          end else begin
            sclk_d = 1'b0;
            if (bit_q == '0) state_d = PUSH;
            else             bit_d   = bit_q - BIT_W'(1);
          end
        end else begin
          ph_d = ph_q + PH_W'(1);
        end
      end
      PUSH: begin
        push    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // A full FIFO still accepts the word if the reader pops in the same cycle.
  assign drop = push & fifo_full & ~bus.rd_en;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q  <= IDLE;
      settle_q <= '0;
      ph_q     <= '0;
      bit_q    <= '0;
      shreg_q  <= '0;
      sclk_q   <= 1'b0;
      busy_q   <= 1'b0;
      sync_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      ph_q     <= ph_d;
      bit_q    <= bit_d;
      shreg_q  <= shreg_d;
      sclk_q   <= sclk_d;
      busy_q   <= (state_d != IDLE);
      sync_q   <= {sync_q[0], bus.sr_in};
      if (drop)             ovf_q <= 1'b1;
      else if (bus.clr_ovf) ovf_q <= 1'b0;
    end
  end

  sync_fifo #(
    .WIDTH(DATA_W),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (wb_clk_i),
    .rst      (wb_rst_i),
    .wr_en    (push),
    .wr_data  (shreg_q),
    .rd_en    (bus.rd_en),
    .rd_data  (fifo_rd_data),
    .empty    (fifo_empty),
    .full     (fifo_full),
    .nonempty (fifo_nonempty)
  );

  assign bus.shift_clk_o = sclk_q;
  assign bus.busy        = busy_q;
  assign bus.rd_data     = fifo_rd_data;
  assign bus.fifo_empty  = fifo_empty;
  assign bus.fifo_full   = fifo_full;
  assign bus.overflow    = ovf_q;
  assign bus.irq         = fifo_nonempty;
endmodule

// File: tb/tb_temp_sr_capture.sv
module tb_temp_sr_capture;
  localparam int DATA_W     = 16;
  localparam int SHIFT_DIV  = 4;
  localparam int SETTLE_CYC = 8;
  localparam int FIFO_DEPTH = 4;
  localparam int CLK_P      = 10;
  localparam int BUSY_CYC   = SETTLE_CYC + 2 * SHIFT_DIV * DATA_W + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #(CLK_P / 2) clk = ~clk;

  temp_sr_capture_if #(.DATA_W(DATA_W)) bus ();

  temp_sr_capture #(
    .DATA_W(DATA_W), .SHIFT_DIV(SHIFT_DIV),
    .SETTLE_CYC(SETTLE_CYC), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .bus      (bus)
  );

  int checks = 0;
  int errs   = 0;

  logic [DATA_W-1:0] exp_q[$];
  bit                exp_ovf = 1'b0;

  // Sensor model: presents its word MSB first and advances one bit per rising shift clock.
  logic [DATA_W-1:0] sens_word = '0;
  int                edge_total = 0;
  int                edge_base  = 0;
  int                gap_err    = 0;
  longint            last_edge_t = 0;
  logic [DATA_W-1:0] sens_shift;
  logic              sens_bit;

  always_comb begin
    sens_shift = sens_word << (edge_total - edge_base);
    sens_bit   = sens_shift[DATA_W-1];
  end
  assign bus.sr_in = sens_bit;

  always @(posedge bus.shift_clk_o) begin
    if (edge_total != edge_base && ($time - last_edge_t) != 2 * SHIFT_DIV * CLK_P)
      gap_err++;
    last_edge_t = $time;
    edge_total++;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, expv);
    end
  endtask

  // Scoreboard monitor: every accepted pop must return the oldest expected word.
  always @(negedge clk) begin
    if (!rst && bus.rd_en && !bus.fifo_empty) begin
      if (exp_q.size() == 0) chk("rd_unexpected_word", 32'(bus.rd_data), 32'hFFFF_FFFF);
      else                   chk("rd_data", 32'(bus.rd_data), 32'(exp_q.pop_front()));
    end
  end

  task automatic conv(input logic [DATA_W-1:0] w, input bit rd_at_push, input int extra_at);
    int  busy_cyc;
    bit  drop;
    drop = (exp_q.size() >= FIFO_DEPTH) && !rd_at_push;
    if (drop) exp_ovf = 1'b1;
    else      exp_q.push_back(w);
    @(posedge clk); #1;
    sens_word = w;
    edge_base = edge_total;
    bus.start = 1'b1;
    busy_cyc  = 0;
    for (int k = 1; k < 1000; k++) begin
      @(posedge clk); #1;
      bus.start = (k == extra_at);
      bus.rd_en = rd_at_push && (k == BUSY_CYC);
      @(negedge clk);
      if (!bus.busy) break;
      busy_cyc++;
    end
    bus.start = 1'b0;
    bus.rd_en = 1'b0;
    chk("busy_cycles", 32'(busy_cyc), 32'(BUSY_CYC));
    chk("shift_edges", 32'(edge_total - edge_base), 32'(DATA_W));
    chk("edge_gap_errors", 32'(gap_err), 32'd0);
    chk("overflow", 32'(bus.overflow), 32'(exp_ovf));
  endtask

  task automatic drain();
    for (int g = 0; g < 50; g++) begin
      @(posedge clk); #1;
      if (bus.fifo_empty) break;
      bus.rd_en = 1'b1;
    end
    bus.rd_en = 1'b0;
    @(negedge clk);
    chk("empty_after_drain", 32'(bus.fifo_empty), 32'd1);
    chk("irq_after_drain", 32'(bus.irq), 32'd0);
    chk("rd_data_when_empty", 32'(bus.rd_data), 32'd0);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic clear_ovf();
    @(posedge clk); #1 bus.clr_ovf = 1'b1;
    @(posedge clk); #1 bus.clr_ovf = 1'b0;
    exp_ovf = 1'b0;
    @(negedge clk);
    chk("overflow_cleared", 32'(bus.overflow), 32'd0);
  endtask

  initial begin
    #(CLK_P * 60000);
    $display("FAIL watchdog: simulation time limit reached before completion");
    $display("Result: errors=%0d of %0d checks", errs + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    bus.start   = 1'b0;
    bus.rd_en   = 1'b0;
    bus.clr_ovf = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_empty", 32'(bus.fifo_empty), 32'd1);
    chk("rst_full", 32'(bus.fifo_full), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_irq", 32'(bus.irq), 32'd0);
    chk("rst_ovf", 32'(bus.overflow), 32'd0);
    chk("rst_rd_data", 32'(bus.rd_data), 32'd0);
    chk("rst_sclk", 32'(bus.shift_clk_o), 32'd0);

    // Single conversion
    conv(16'hA5C3, 1'b0, 0);
    chk("single_irq", 32'(bus.irq), 32'd1);
    chk("single_empty", 32'(bus.fifo_empty), 32'd0);
    chk("single_head", 32'(bus.rd_data), 32'hA5C3);
    drain();

    // Start while busy is ignored
    conv(16'h3C96, 1'b0, 20);
    chk("busy_start_one_entry_irq", 32'(bus.irq), 32'd1);
    drain();

    // Fill and overflow
    for (int i = 1; i <= 5; i++) begin
      conv(16'(i), 1'b0, 0);
      if (i == 4) chk("fill_full", 32'(bus.fifo_full), 32'd1);
    end
    chk("fill_overflow_set", 32'(bus.overflow), 32'd1);
    drain();
    clear_ovf();

    // Push and pop in the same cycle while full
    for (int i = 0; i < 4; i++) conv(16'($urandom), 1'b0, 0);
    conv(16'h1234, 1'b1, 0);
    chk("pushpop_full", 32'(bus.fifo_full), 32'd1);
    chk("pushpop_no_ovf", 32'(bus.overflow), 32'd0);
    drain();

    // Extreme data
    conv(16'h0000, 1'b0, 0);
    conv(16'hFFFF, 1'b0, 0);
    drain();

    // Randomized conversions, stray starts and partial draining
    for (int i = 0; i < 8; i++) begin
      conv(16'($urandom), 1'b0, ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, BUSY_CYC)) : 0);
      if ($urandom_range(0, 2) == 0) drain();
    end
    drain();
    clear_ovf();

    // Reset mid-conversion with full FIFO and overflow set
    for (int i = 0; i < 5; i++) conv(16'($urandom), 1'b0, 0);
    chk("pre_reset_ovf", 32'(bus.overflow), 32'd1);
    @(posedge clk); #1;
    sens_word = 16'($urandom);
    edge_base = edge_total;
    bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    found = 1'b0;
    for (int g = 0; g < 400; g++) begin
      @(negedge clk);
      if (bus.shift_clk_o) begin
        found = 1'b1;
        break;
      end
    end
    chk("sclk_seen_high", 32'(found), 32'd1);
    rst = 1'b1;
    #1;
    chk("async_rst_sclk", 32'(bus.shift_clk_o), 32'd0);
    chk("async_rst_busy", 32'(bus.busy), 32'd0);
    chk("async_rst_empty", 32'(bus.fifo_empty), 32'd1);
    chk("async_rst_ovf", 32'(bus.overflow), 32'd0);
    chk("async_rst_irq", 32'(bus.irq), 32'd0);
    exp_q.delete();
    exp_ovf = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (200) @(negedge clk);
    chk("post_rst_empty", 32'(bus.fifo_empty), 32'd1);
    chk("post_rst_busy", 32'(bus.busy), 32'd0);
    chk("post_rst_irq", 32'(bus.irq), 32'd0);
    chk("post_rst_ovf", 32'(bus.overflow), 32'd0);
    chk("post_rst_sclk", 32'(bus.shift_clk_o), 32'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
